// File: rtl/latch2bit_serial_tx.sv
// Serial transmitter for 2-bit words: a small FIFO feeds a framer that sends
// start, D[1], D[0], stop on tx, each bit held for DIV clock cycles.
module latch2bit_serial_tx #(
  parameter int DEPTH = 4,
  parameter int DIV   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [1:0]                   D,
  output logic                         ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [BW-1:0] LAST = BW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BIT1, BIT0, STOP} state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [BW-1:0] bit_cnt;
  logic [1:0]    shift;
  logic          wr;
  logic          pop;
  logic          bit_end;

  // ready comes from the registered count, so a full FIFO refuses a write
  // even on the edge that pops.
  assign ready   = (count != FULL);
  assign wr      = en && ready;
  assign bit_end = (bit_cnt == LAST);
  assign pop     = (count != '0) && ((state == IDLE) || (state == STOP && bit_end));

  always_ff @(posedge clk) begin
    if (!reset && wr) mem[wr_ptr] <= D;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          tx      <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START, BIT1, BIT0: begin
          if (!bit_end) begin
            bit_cnt <= bit_cnt + BW'(1);
          end else begin
            bit_cnt <= '0;
            case (state)
              START:   begin tx <= shift[1]; state <= BIT1; end
              BIT1:    begin tx <= shift[0]; state <= BIT0; end
              default: begin tx <= 1'b1;     state <= STOP; end
            endcase
          end
        end
        STOP: begin
          if (!bit_end) begin
            bit_cnt <= bit_cnt + BW'(1);
          end else begin
            bit_cnt <= '0;
            // Back-to-back launch straight out of STOP keeps the line gap-free.
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch2bit_serial_tx.sv
// Randomized bench for latch2bit_serial_tx: a queue-based frame model gives
// the expected line level each cycle, and a line decoder recovers sent words.
module tb_latch2bit_serial_tx;

  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int FLEN  = 4 * DIV;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] D;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [$clog2(DEPTH+1)-1:0] count;

  latch2bit_serial_tx #(.DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .en(en), .D(D),
    .ready(ready), .tx(tx), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: pending words, the frame on the line and its age
  logic [1:0] q[$];
  logic [1:0] launched[$];
  logic [1:0] cur;
  bit         active;
  int         t;
  logic       m_tx;

  // line decoder state
  bit         dec_active;
  int         dec_t;
  logic       b1, b0;
  int         dec_frames;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic line_level(input int age, input logic [1:0] w);
    case (age / DIV)
      0:       return 1'b0;
      1:       return w[1];
      2:       return w[0];
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [1:0] d);
    bit wr_ok, fin, launch;
    if (r) begin
      q.delete();
      launched.delete();
      active = 0;
      t = 0;
    end else begin
      wr_ok  = e && (q.size() < DEPTH);
      fin    = active && (t == FLEN - 1);
      launch = (q.size() > 0) && (!active || fin);
      if (launch) begin
        cur = q.pop_front();
        launched.push_back(cur);
        active = 1;
        t = 0;
      end else if (fin) begin
        active = 0;
      end else if (active) begin
        t++;
      end
      if (wr_ok) q.push_back(d);
    end
    m_tx = active ? line_level(t, cur) : 1'b1;
  endtask

  task automatic decode(input logic r);
    int exp_w;
    if (r) begin
      dec_active = 0;
      return;
    end
    if (!dec_active) begin
      if (tx == 1'b0) begin
        dec_active = 1;
        dec_t = 0;
      end
    end else begin
      dec_t++;
    end
    if (dec_active) begin
      if (dec_t == DIV + DIV/2)   b1 = tx;
      if (dec_t == 2*DIV + DIV/2) b0 = tx;
      if (dec_t == 3*DIV + DIV/2) check_eq("stop_bit", tx, 1);
      if (dec_t == FLEN - 1) begin
        exp_w = (launched.size() > 0) ? int'(launched.pop_front()) : -1;
        check_eq("frame_word", int'({b1, b0}), exp_w);
        dec_frames++;
        dec_active = 0;
      end
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic [1:0] d);
    reset = r; en = e; D = d;
    @(posedge clk);
    model_step(r, e, d);
    #1;
    check_eq("tx", tx, m_tx);
    check_eq("busy", busy, int'(active));
    check_eq("count", count, q.size());
    check_eq("ready", ready, int'(q.size() < DEPTH));
    decode(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 2'b00);
  endtask

  initial begin
    clk = 0; reset = 1; en = 0; D = 0;
    active = 0; t = 0; cur = 0; m_tx = 1;
    dec_active = 0; dec_t = 0; b1 = 0; b0 = 0; dec_frames = 0;

    tick(1, 0, 0);
    tick(1, 1, 2'b11);
    idle(3);

    // single word 10
    dec_frames = 0;
    tick(0, 1, 2'b10);
    idle(16);
    check_eq("single_busy_k16", busy, 1);
    idle(1);
    check_eq("single_busy_k17", busy, 0);
    idle(4);
    check_eq("single_frames", dec_frames, 1);

    // back-to-back 01, 11, 00
    dec_frames = 0;
    tick(0, 1, 2'b01);
    tick(0, 1, 2'b11);
    tick(0, 1, 2'b00);
    idle(3 * FLEN + 6);
    check_eq("b2b_frames", dec_frames, 3);

    // full FIFO: en held during the first frame only
    dec_frames = 0;
    for (int i = 0; i < 12; i++) tick(0, 1, 2'b11);
    idle(5 * FLEN);
    check_eq("full_frames", dec_frames, 5);

    // en held across the pop edge while full
    for (int i = 0; i < 24; i++) tick(0, 1, 2'(i));
    idle(6 * FLEN);

    // reset mid-frame with words queued
    tick(0, 1, 2'b10);
    tick(0, 1, 2'b01);
    idle(6);
    tick(1, 0, 0);
    tick(1, 1, 2'b01);
    dec_frames = 0;
    idle(3 * FLEN);
    check_eq("post_reset_frames", dec_frames, 0);

    // wrap-around: 12 words, spaced so the FIFO never fills
    dec_frames = 0;
    for (int w = 0; w < 12; w++) begin
      tick(0, 1, 2'($urandom_range(0, 3)));
      idle(11);
    end
    idle(8 * FLEN);
    check_eq("wrap_frames", dec_frames, 12);

    // random traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)));
    end
    idle(6 * FLEN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
